br_amba_axi_mem_target: RTL and testbench

// AXI4 responder (subordinate) terminating a target_* AXI4 interface into an internal flop-array memory.

---
 rtl/br_amba.sv | 5 +
 rtl/br_amba_axi_mem_target.sv | 215 +++++++++++++++++++++
 tb/tb_br_amba_axi_mem_target.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/br_amba.sv
// Shared AMBA field widths used by the AXI endpoints.
package br_amba;
  localparam int AxiBurstLenWidth = 8;
  localparam int AxiRespWidth     = 2;
endpackage

// File: rtl/br_amba_axi_mem_target.sv
// AXI4 subordinate backed by a flop-array memory: one outstanding write and one
// outstanding read, INCR full-width bursts, DECERR outside the backed span.
module br_amba_axi_mem_target #(
  parameter int AddrWidth = 12,
  parameter int DataWidth = 32,
  parameter int IdWidth   = 1,
  parameter int Depth     = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [AddrWidth-1:0]                  target_awaddr,
  input  logic [IdWidth-1:0]                    target_awid,
  input  logic [br_amba::AxiBurstLenWidth-1:0]  target_awlen,
  input  logic                                  target_awvalid,
  output logic                                  target_awready,
  input  logic [DataWidth-1:0]                  target_wdata,
  input  logic [DataWidth/8-1:0]                target_wstrb,
  input  logic                                  target_wlast,
  input  logic                                  target_wvalid,
  output logic                                  target_wready,
  output logic [IdWidth-1:0]                    target_bid,
  output logic [br_amba::AxiRespWidth-1:0]      target_bresp,
  output logic                                  target_bvalid,
  input  logic                                  target_bready,
  input  logic [AddrWidth-1:0]                  target_araddr,
  input  logic [IdWidth-1:0]                    target_arid,
  input  logic [br_amba::AxiBurstLenWidth-1:0]  target_arlen,
  input  logic                                  target_arvalid,
  output logic                                  target_arready,
  output logic [IdWidth-1:0]                    target_rid,
  output logic [DataWidth-1:0]                  target_rdata,
  output logic [br_amba::AxiRespWidth-1:0]      target_rresp,
  output logic                                  target_rlast,
  output logic                                  target_rvalid,
  input  logic                                  target_rready
);
  localparam int StrobeWidth = DataWidth / 8;
  localparam int OffsetBits  = $clog2(StrobeWidth);
  localparam int IndexBits   = $clog2(Depth);
  localparam int LenWidth    = br_amba::AxiBurstLenWidth;
  localparam int RespWidth   = br_amba::AxiRespWidth;
  // Span-1 truncated to AddrWidth becomes all-ones when the span covers the
  // whole address space, which leaves no address out of range.
  localparam logic [AddrWidth-1:0] SpanMask = AddrWidth'(Depth * StrobeWidth - 1);
  localparam logic [AddrWidth-1:0] BeatStep = AddrWidth'(StrobeWidth);
  localparam logic [RespWidth-1:0] RespOkay   = RespWidth'(0);
  localparam logic [RespWidth-1:0] RespSlverr = RespWidth'(2);
  localparam logic [RespWidth-1:0] RespDecerr = RespWidth'(3);

  typedef enum logic [1:0] {WrIdle = 2'd0, WrData = 2'd1, WrResp = 2'd2} wr_state_e;
  typedef enum logic {RdIdle = 1'b0, RdData = 1'b1} rd_state_e;

  function automatic logic in_range(input logic [AddrWidth-1:0] a);
    return (a & ~SpanMask) == '0;
  endfunction

  function automatic logic [IndexBits-1:0] word_index(input logic [AddrWidth-1:0] a);
    return a[OffsetBits +: IndexBits];
  endfunction

  wr_state_e               wr_state_q, wr_state_d;
  logic [IdWidth-1:0]      wr_id_q, wr_id_d;
  logic [AddrWidth-1:0]    wr_addr_q, wr_addr_d;
  logic [LenWidth-1:0]     wr_len_q, wr_len_d, wr_cnt_q, wr_cnt_d;
  logic [RespWidth-1:0]    wr_resp_q, wr_resp_d, wr_beat_resp;
  logic [DataWidth-1:0]    mem_q [Depth];
  logic [DataWidth-1:0]    mem_d [Depth];
  rd_state_e               rd_state_q, rd_state_d;
  logic [IdWidth-1:0]      rd_id_q, rd_id_d;
  logic [AddrWidth-1:0]    rd_addr_q, rd_addr_d, rd_beat_addr;
  logic [LenWidth-1:0]     rd_len_q, rd_len_d, rd_cnt_q, rd_cnt_d;
  logic [DataWidth-1:0]    rdata_q, rdata_d, rd_beat_data;
  logic [RespWidth-1:0]    rresp_q, rresp_d, rd_beat_resp;
  logic                    rlast_q, rlast_d;
  logic                    aw_hs, w_hs, ar_hs, wr_last_beat;

  assign target_awready = (wr_state_q == WrIdle) && !rst;
  assign target_wready  = (wr_state_q == WrData) && !rst;
  assign target_bvalid  = (wr_state_q == WrResp) && !rst;
  assign target_bid     = wr_id_q;
  assign target_bresp   = wr_resp_q;
  assign target_arready = (rd_state_q == RdIdle) && !rst;
  assign target_rvalid  = (rd_state_q == RdData) && !rst;
  assign target_rid     = rd_id_q;
  assign target_rdata   = rdata_q;
  assign target_rresp   = rresp_q;
  assign target_rlast   = rlast_q;

  assign aw_hs        = target_awvalid && target_awready;
  assign w_hs         = target_wvalid && target_wready;
  assign ar_hs        = target_arvalid && target_arready;
  assign wr_last_beat = (wr_cnt_q == wr_len_q);

  always_comb begin
    wr_state_d   = wr_state_q;
    wr_id_d      = wr_id_q;
    wr_addr_d    = wr_addr_q;
    wr_len_d     = wr_len_q;
    wr_cnt_d     = wr_cnt_q;
    wr_resp_d    = wr_resp_q;
    wr_beat_resp = RespOkay;
    mem_d        = mem_q;
    unique case (wr_state_q)
      WrIdle: begin
        if (aw_hs) begin
          wr_id_d    = target_awid;
          wr_addr_d  = target_awaddr;
          wr_len_d   = target_awlen;
          wr_cnt_d   = '0;
          wr_resp_d  = RespOkay;
          wr_state_d = WrData;
        end
      end
      WrData: begin
        if (w_hs) begin
          if (in_range(wr_addr_q)) begin
            for (int unsigned b = 0; b < StrobeWidth; b++) begin
              if (target_wstrb[b]) mem_d[word_index(wr_addr_q)][8*b +: 8] = target_wdata[8*b +: 8];
            end
          end
          // Response codes are ordered by severity, so keeping the maximum lets DECERR win.
          if (!in_range(wr_addr_q)) wr_beat_resp = RespDecerr;
          else if (target_wlast != wr_last_beat) wr_beat_resp = RespSlverr;
          if (wr_beat_resp > wr_resp_q) wr_resp_d = wr_beat_resp;
          wr_addr_d = wr_addr_q + BeatStep;
          wr_cnt_d  = wr_cnt_q + LenWidth'(1);
          if (wr_last_beat) wr_state_d = WrResp;
        end
      end
      WrResp: begin
        if (target_bready) wr_state_d = WrIdle;
      end
      default: wr_state_d = WrIdle;
    endcase
  end

  // Beat data is fetched from the pre-edge memory, so a same-cycle write is not seen.
  always_comb begin
    rd_beat_addr = (rd_state_q == RdIdle) ? target_araddr : rd_addr_q;
    rd_beat_data = in_range(rd_beat_addr) ? mem_q[word_index(rd_beat_addr)] : '0;
    rd_beat_resp = in_range(rd_beat_addr) ? RespOkay : RespDecerr;
    rd_state_d   = rd_state_q;
    rd_id_d      = rd_id_q;
    rd_addr_d    = rd_addr_q;
    rd_len_d     = rd_len_q;
    rd_cnt_d     = rd_cnt_q;
    rdata_d      = rdata_q;
    rresp_d      = rresp_q;
    rlast_d      = rlast_q;
    unique case (rd_state_q)
      RdIdle: begin
        if (ar_hs) begin
          rd_id_d    = target_arid;
          rd_len_d   = target_arlen;
          rd_addr_d  = target_araddr + BeatStep;
          rd_cnt_d   = LenWidth'(1);
          rdata_d    = rd_beat_data;
          rresp_d    = rd_beat_resp;
          rlast_d    = (target_arlen == '0);
          rd_state_d = RdData;
        end
      end
      RdData: begin
        if (target_rready) begin
          if (rlast_q) begin
            rd_state_d = RdIdle;
          end else begin
            rd_addr_d = rd_addr_q + BeatStep;
            rd_cnt_d  = rd_cnt_q + LenWidth'(1);
            rdata_d   = rd_beat_data;
            rresp_d   = rd_beat_resp;
            rlast_d   = (rd_cnt_q == rd_len_q);
          end
        end
      end
      default: rd_state_d = RdIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= WrIdle;
      wr_id_q    <= '0;
      wr_addr_q  <= '0;
      wr_len_q   <= '0;
      wr_cnt_q   <= '0;
      wr_resp_q  <= '0;
      mem_q      <= '{default: '0};
      rd_state_q <= RdIdle;
      rd_id_q    <= '0;
      rd_addr_q  <= '0;
      rd_len_q   <= '0;
      rd_cnt_q   <= '0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      rlast_q    <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_id_q    <= wr_id_d;
      wr_addr_q  <= wr_addr_d;
      wr_len_q   <= wr_len_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_resp_q  <= wr_resp_d;
      mem_q      <= mem_d;
      rd_state_q <= rd_state_d;
      rd_id_q    <= rd_id_d;
      rd_addr_q  <= rd_addr_d;
      rd_len_q   <= rd_len_d;
      rd_cnt_q   <= rd_cnt_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rlast_q    <= rlast_d;
    end
  end
endmodule

// File: tb/tb_br_amba_axi_mem_target.sv
// Self-checking bench for br_amba_axi_mem_target: vector table, directed corner
// sequences and randomized bursts against a word-array reference model.
module tb_br_amba_axi_mem_target;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int IW = 1;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] target_awaddr, target_araddr;
  logic [IW-1:0] target_awid, target_arid, target_bid, target_rid;
  logic [7:0]    target_awlen, target_arlen;
  logic          target_awvalid, target_awready, target_wlast, target_wvalid, target_wready;
  logic [DW-1:0] target_wdata, target_rdata;
  logic [3:0]    target_wstrb;
  logic [1:0]    target_bresp, target_rresp;
  logic          target_bvalid, target_bready, target_arvalid, target_arready;
  logic          target_rlast, target_rvalid, target_rready;

  br_amba_axi_mem_target #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .Depth(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .target_awaddr(target_awaddr), .target_awid(target_awid), .target_awlen(target_awlen),
    .target_awvalid(target_awvalid), .target_awready(target_awready),
    .target_wdata(target_wdata), .target_wstrb(target_wstrb), .target_wlast(target_wlast),
    .target_wvalid(target_wvalid), .target_wready(target_wready),
    .target_bid(target_bid), .target_bresp(target_bresp), .target_bvalid(target_bvalid),
    .target_bready(target_bready),
    .target_araddr(target_araddr), .target_arid(target_arid), .target_arlen(target_arlen),
    .target_arvalid(target_arvalid), .target_arready(target_arready),
    .target_rid(target_rid), .target_rdata(target_rdata), .target_rresp(target_rresp),
    .target_rlast(target_rlast), .target_rvalid(target_rvalid), .target_rready(target_rready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] wd_v [16];
  logic [3:0]  ws_v [16];
  logic        wl_v [16];

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_bresp;
    logic [1:0]  exp_rresp;
  } vec_t;
  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  task automatic idle_inputs();
    target_awaddr = '0; target_awid = '0; target_awlen = '0; target_awvalid = 1'b0;
    target_wdata = '0; target_wstrb = '0; target_wlast = 1'b0; target_wvalid = 1'b0;
    target_bready = 1'b0;
    target_araddr = '0; target_arid = '0; target_arlen = '0; target_arvalid = 1'b0;
    target_rready = 1'b0;
  endtask

  task automatic send_aw(input logic [11:0] addr, input logic [IW-1:0] id, input logic [7:0] len, output bit ok);
    target_awaddr = addr; target_awid = id; target_awlen = len; target_awvalid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (target_awready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    else timeout("aw_handshake");
    target_awvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [11:0] addr, input logic [IW-1:0] id, input logic [7:0] len, output bit ok);
    target_araddr = addr; target_arid = id; target_arlen = len; target_arvalid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (target_arready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    else timeout("ar_handshake");
    target_arvalid = 1'b0;
  endtask

  // Write burst using wd_v/ws_v/wl_v; the model is updated from the burst rules.
  task automatic wr_burst(input logic [11:0] addr, input logic [IW-1:0] id, input int len,
                          input int gap_pct, input int bdelay, output logic [1:0] resp_seen);
    bit ok, oor, slv;
    logic [31:0] a;
    logic [1:0] exp_resp, snap_resp;
    logic [IW-1:0] snap_id;
    resp_seen = '0;
    send_aw(addr, id, 8'(len), ok);
    if (!ok) return;
    check("wready_after_aw", 64'(target_wready), 64'd1);
    check("awready_busy", 64'(target_awready), 64'd0);
    for (int i = 0; i <= len; i++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        target_wvalid = 1'b0;
        @(negedge clk);
      end
      target_wvalid = 1'b1; target_wdata = wd_v[i]; target_wstrb = ws_v[i]; target_wlast = wl_v[i];
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
        if (target_wready) begin ok = 1'b1; break; end
        @(negedge clk);
      end
      if (!ok) begin
        target_wvalid = 1'b0;
        timeout("w_handshake");
        return;
      end
      @(negedge clk);
    end
    target_wvalid = 1'b0; target_wlast = 1'b0;
    oor = 1'b0; slv = 1'b0;
    for (int i = 0; i <= len; i++) begin
      a = (32'(addr) + 32'(4 * i)) & 32'hFFF;
      if (a < 32'd64) begin
        for (int b = 0; b < 4; b++)
          if (ws_v[i][b]) model_mem[a[5:2]][8*b +: 8] = wd_v[i][8*b +: 8];
      end else oor = 1'b1;
      if (wl_v[i] != (i == len)) slv = 1'b1;
    end
    exp_resp = oor ? 2'd3 : (slv ? 2'd2 : 2'd0);
    check("bvalid_after_last_w", 64'(target_bvalid), 64'd1);
    snap_resp = target_bresp; snap_id = target_bid;
    repeat (bdelay) begin
      @(negedge clk);
      check("bvalid_held", 64'(target_bvalid), 64'd1);
      check("bresp_stable", 64'(target_bresp), 64'(snap_resp));
      check("bid_stable", 64'(target_bid), 64'(snap_id));
    end
    check("bresp", 64'(target_bresp), 64'(exp_resp));
    check("bid", 64'(target_bid), 64'(id));
    resp_seen = target_bresp;
    target_bready = 1'b1;
    @(negedge clk);
    target_bready = 1'b0;
    check("bvalid_after_b", 64'(target_bvalid), 64'd0);
    check("awready_after_b", 64'(target_awready), 64'd1);
  endtask

  task automatic rd_burst(input logic [11:0] addr, input logic [IW-1:0] id, input int len,
                          input int stall_pct, input int stall_beat, input int stall_cycles,
                          output logic [31:0] first_data, output logic [31:0] last_data,
                          output logic [1:0] last_resp);
    bit ok, have_snap;
    int beat, stalled;
    logic [31:0] a, e_data, s_data;
    logic [1:0] e_resp, s_resp;
    logic s_last;
    first_data = '0; last_data = '0; last_resp = '0;
    send_ar(addr, id, 8'(len), ok);
    if (!ok) return;
    beat = 0; stalled = 0; have_snap = 1'b0;
    s_data = '0; s_resp = '0; s_last = 1'b0;
    for (int cyc = 0; cyc < 400 && beat <= len; cyc++) begin
      if (beat == stall_beat && stalled < stall_cycles) begin
        target_rready = 1'b0;
        stalled++;
      end else target_rready = ($urandom_range(0, 99) >= stall_pct);
      check("rvalid_in_burst", 64'(target_rvalid), 64'd1);
      if (have_snap) begin
        check("rdata_stable", 64'(target_rdata), 64'(s_data));
        check("rresp_stable", 64'(target_rresp), 64'(s_resp));
        check("rlast_stable", 64'(target_rlast), 64'(s_last));
      end
      if (target_rready) begin
        a = (32'(addr) + 32'(4 * beat)) & 32'hFFF;
        e_data = (a < 32'd64) ? model_mem[a[5:2]] : 32'd0;
        e_resp = (a < 32'd64) ? 2'd0 : 2'd3;
        check("rdata", 64'(target_rdata), 64'(e_data));
        check("rresp", 64'(target_rresp), 64'(e_resp));
        check("rlast", 64'(target_rlast), 64'(beat == len));
        check("rid", 64'(target_rid), 64'(id));
        if (beat == 0) first_data = target_rdata;
        last_data = target_rdata;
        last_resp = target_rresp;
        beat++;
        have_snap = 1'b0;
      end else if (!have_snap) begin
        s_data = target_rdata; s_resp = target_rresp; s_last = target_rlast;
        have_snap = 1'b1;
      end
      @(negedge clk);
    end
    target_rready = 1'b0;
    if (beat <= len) timeout("r_burst");
    else begin
      check("rvalid_after_rlast", 64'(target_rvalid), 64'd0);
      check("arready_after_rlast", 64'(target_arready), 64'd1);
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_awready"}, 64'(target_awready), 64'd0);
    check({tag, "_arready"}, 64'(target_arready), 64'd0);
    check({tag, "_wready"}, 64'(target_wready), 64'd0);
    check({tag, "_bvalid"}, 64'(target_bvalid), 64'd0);
    check({tag, "_rvalid"}, 64'(target_rvalid), 64'd0);
    check({tag, "_bresp"}, 64'(target_bresp), 64'd0);
    check({tag, "_bid"}, 64'(target_bid), 64'd0);
    check({tag, "_rid"}, 64'(target_rid), 64'd0);
    check({tag, "_rdata"}, 64'(target_rdata), 64'd0);
    check({tag, "_rresp"}, 64'(target_rresp), 64'd0);
    check({tag, "_rlast"}, 64'(target_rlast), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    logic [1:0] rs;
    logic [31:0] f, l;
    int len;
    vecs[0] = '{12'h000, 32'h11223344, 4'hF, 32'h11223344, 2'd0, 2'd0};
    vecs[1] = '{12'h000, 32'hFFFFFFFF, 4'h3, 32'h1122FFFF, 2'd0, 2'd0};
    vecs[2] = '{12'h004, 32'hDEADBEEF, 4'hC, 32'hDEAD0000, 2'd0, 2'd0};
    vecs[3] = '{12'h007, 32'h000000AB, 4'h1, 32'hDEAD00AB, 2'd0, 2'd0};
    vecs[4] = '{12'h040, 32'h5A5A5A5A, 4'hF, 32'h00000000, 2'd3, 2'd3};
    vecs[5] = '{12'h03C, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D, 2'd0, 2'd0};
    vecs[6] = '{12'h07C, 32'h00000000, 4'hF, 32'h00000000, 2'd3, 2'd3};
    vecs[7] = '{12'h03E, 32'h00000000, 4'h0, 32'hCAFEF00D, 2'd0, 2'd0};
    vecs[8] = '{12'hFFC, 32'h12345678, 4'hF, 32'h00000000, 2'd3, 2'd3};
    vecs[9] = '{12'h000, 32'h00AA0000, 4'h4, 32'h11AAFFFF, 2'd0, 2'd0};

    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    reset_checks("por");
    rst = 1'b0;
    clear_model();
    @(negedge clk);
    check("por_awready_after", 64'(target_awready), 64'd1);
    check("por_arready_after", 64'(target_arready), 64'd1);

    for (int i = 0; i < 10; i++) begin
      wd_v[0] = vecs[i].data; ws_v[0] = vecs[i].strb; wl_v[0] = 1'b1;
      wr_burst(vecs[i].addr, 1'b0, 0, 0, 0, rs);
      check($sformatf("vec%0d_bresp", i), 64'(rs), 64'(vecs[i].exp_bresp));
      rd_burst(vecs[i].addr, 1'b1, 0, 0, -1, 0, f, l, rs);
      check($sformatf("vec%0d_rdata", i), 64'(f), 64'(vecs[i].exp_rdata));
      check($sformatf("vec%0d_rresp", i), 64'(rs), 64'(vecs[i].exp_rresp));
    end

    // Two-beat write/read at 0x8 with id 1.
    wd_v[0] = 32'hAAAA5555; wd_v[1] = 32'h12345678; ws_v[0] = 4'hF; ws_v[1] = 4'hF;
    wl_v[0] = 1'b0; wl_v[1] = 1'b1;
    wr_burst(12'h008, 1'b1, 1, 0, 2, rs);
    check("seqA_bresp", 64'(rs), 64'd0);
    rd_burst(12'h008, 1'b0, 1, 0, -1, 0, f, l, rs);
    check("seqA_beat0", 64'(f), 64'hAAAA5555);
    check("seqA_beat1", 64'(l), 64'h12345678);

    // Burst running off the end of the backed span.
    wd_v[0] = 32'h01020304; wd_v[1] = 32'h05060708;
    wr_burst(12'h03C, 1'b0, 1, 0, 0, rs);
    check("seqC_bresp", 64'(rs), 64'd3);
    rd_burst(12'h03C, 1'b1, 1, 0, -1, 0, f, l, rs);
    check("seqC_beat0", 64'(f), 64'h01020304);
    check("seqC_beat1_data", 64'(l), 64'd0);
    check("seqC_beat1_resp", 64'(rs), 64'd3);

    // Early wlast on a three-beat burst.
    wd_v[0] = 32'h10101010; wd_v[1] = 32'h20202020; wd_v[2] = 32'h30303030; ws_v[2] = 4'hF;
    wl_v[0] = 1'b0; wl_v[1] = 1'b1; wl_v[2] = 1'b0;
    wr_burst(12'h010, 1'b1, 2, 0, 1, rs);
    check("seqD_bresp", 64'(rs), 64'd2);

    // Address wrap: beat 0 at 0xFFC is out of range, beat 1 wraps to 0x000.
    wd_v[0] = 32'h99999999; wd_v[1] = 32'h76543210; wl_v[0] = 1'b0; wl_v[1] = 1'b1;
    wr_burst(12'hFFC, 1'b0, 1, 0, 0, rs);
    check("wrap_bresp", 64'(rs), 64'd3);
    rd_burst(12'h000, 1'b0, 0, 0, -1, 0, f, l, rs);
    check("wrap_word0", 64'(f), 64'h76543210);

    // Four-beat read with a five-cycle stall on beat 2.
    rd_burst(12'h010, 1'b1, 3, 0, 2, 5, f, l, rs);
    check("seqE_beat0", 64'(f), 64'h10101010);

    // Same-cycle write and read of word 2.
    send_aw(12'h008, 1'b0, 8'd0, ok);
    target_wvalid = 1'b1; target_wdata = 32'h0BADF00D; target_wstrb = 4'hF; target_wlast = 1'b1;
    target_araddr = 12'h008; target_arid = 1'b0; target_arlen = 8'd0; target_arvalid = 1'b1;
    check("coll_wready", 64'(target_wready), 64'd1);
    check("coll_arready", 64'(target_arready), 64'd1);
    @(negedge clk);
    target_wvalid = 1'b0; target_wlast = 1'b0; target_arvalid = 1'b0;
    check("coll_rvalid", 64'(target_rvalid), 64'd1);
    check("coll_old_data", 64'(target_rdata), 64'hAAAA5555);
    check("coll_bvalid", 64'(target_bvalid), 64'd1);
    target_rready = 1'b1; target_bready = 1'b1;
    @(negedge clk);
    target_rready = 1'b0; target_bready = 1'b0;
    model_mem[2] = 32'h0BADF00D;
    rd_burst(12'h008, 1'b0, 0, 0, -1, 0, f, l, rs);
    check("coll_new_data", 64'(f), 64'h0BADF00D);

    for (int it = 0; it < 30; it++) begin
      len = $urandom_range(0, 3);
      for (int i = 0; i <= len; i++) begin
        wd_v[i] = $urandom; ws_v[i] = 4'($urandom); wl_v[i] = (i == len);
      end
      if ($urandom_range(0, 7) == 0) begin
        int j;
        j = $urandom_range(0, len);
        wl_v[j] = ~wl_v[j];
      end
      wr_burst(12'($urandom_range(0, 79)), IW'($urandom), len, 25, $urandom_range(0, 2), rs);
      rd_burst(12'($urandom_range(0, 79)), IW'($urandom), $urandom_range(0, 3), 30, -1, 0, f, l, rs);
    end

    // Reset in the middle of a read burst.
    send_ar(12'h000, 1'b1, 8'd3, ok);
    target_rready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    reset_checks("rst_rd");
    rst = 1'b0;
    clear_model();
    @(negedge clk);
    check("rst_rd_awready", 64'(target_awready), 64'd1);
    check("rst_rd_arready", 64'(target_arready), 64'd1);
    check("rst_rd_rvalid", 64'(target_rvalid), 64'd0);

    // Reset in the middle of a write burst.
    send_aw(12'h010, 1'b1, 8'd3, ok);
    target_wvalid = 1'b1; target_wdata = 32'hFEEDFACE; target_wstrb = 4'hF; target_wlast = 1'b0;
    @(negedge clk);
    target_wvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    reset_checks("rst_wr");
    rst = 1'b0;
    @(negedge clk);
    check("rst_wr_awready", 64'(target_awready), 64'd1);
    check("rst_wr_arready", 64'(target_arready), 64'd1);
    check("rst_wr_wready", 64'(target_wready), 64'd0);
    rd_burst(12'h010, 1'b0, 0, 0, -1, 0, f, l, rs);
    check("rst_wr_cleared", 64'(f), 64'd0);
    rd_burst(12'h000, 1'b0, 15, 20, -1, 0, f, l, rs);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
